dac121s101_interface: RTL and testbench

Serial writer for one or more TI DAC121S101 12-bit DACs (Digilent PMOD DA2) sharing one SCLK and one SYNC_n line, each DAC on its own data line. Accepts one parallel sample word per device through a valid/ready handshake and shifts it out as a 16-bit frame. It is the output-side counterpart of the AD7476A sampling path: ADC samples (or processed values) enter here and drive the PMOD DA2 pins.

---
 rtl/dac121s101_interface.sv | 179 +++++++++++++++++
 tb/tb_dac121s101_interface.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac121s101_interface.sv
// -----------------------------------------------------------------------------
// dac121s101_interface
//   Serial writer for one or more TI DAC121S101 12-bit DACs (PMOD DA2) that
//   share SCLK and SYNC_n, each DAC on its own data line. One parallel word per
//   device is accepted through a valid/ready handshake and shifted out as a
//   16-bit frame {2'b00, pd[1:0], data[11:0]}, MSB first.
//
// Ports
//   clk_i         system clock (CLK_FREQ_HZ)
//   rst           synchronous, active-high reset
//   data_i        sample words, data_i[12*i+11:12*i] -> device i
//   pd_i          power-down field shared by all devices (00 = normal)
//   data_valid_i  data_i/pd_i hold a frame to send
//   ready_o       idle, a frame is accepted this cycle
//   frame_done_o  one-cycle pulse on the first SYNC_n-high cycle after a frame
//   sclk_o        DAC serial clock, idles high
//   sync_n_o      DAC frame sync, active low
//   sdata_o       serial data, bit i -> device i
//
// Handshake: a frame is accepted on a rising clk_i edge where data_valid_i and
// ready_o are both high. data_valid_i may be raised at any time and is only
// looked at while ready_o is high; there is no queueing.
// -----------------------------------------------------------------------------
module dac121s101_interface #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int SCLK_FREQ_HZ = 25_000_000,
  parameter int NUM_DEVICES  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst,
  input  logic [12*NUM_DEVICES-1:0] data_i,
  input  logic [1:0]                pd_i,
  input  logic                      data_valid_i,
  output logic                      ready_o,
  output logic                      frame_done_o,
  output logic                      sclk_o,
  output logic                      sync_n_o,
  output logic [NUM_DEVICES-1:0]    sdata_o
);

  // Clock cycles per SCLK half-period, rounded up so SCLK never exceeds the
  // requested rate.
  localparam int H  = (CLK_FREQ_HZ + 2 * SCLK_FREQ_HZ - 1) / (2 * SCLK_FREQ_HZ);
  localparam int HW = $clog2(H + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(H - 1);

  generate
    if (SCLK_FREQ_HZ > 30_000_000 || SCLK_FREQ_HZ > CLK_FREQ_HZ / 2 || H < 1) begin : g_bad_sclk
      $error("dac121s101_interface: SCLK_FREQ_HZ must be <= 30 MHz and <= CLK_FREQ_HZ/2");
    end
  endgenerate

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic          low_q, low_d;      // 1 while in the SCLK-low half of a bit
  logic [4:0]    bit_q, bit_d;
  logic [15:0]   shift_q [NUM_DEVICES];
  logic [15:0]   shift_d [NUM_DEVICES];

  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   sclk_q, sclk_d;
  logic                   sync_n_q, sync_n_d;
  logic [NUM_DEVICES-1:0] sdata_q, sdata_d;

  logic half_end;

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    low_d    = low_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    half_end = (half_q == HALF_LAST);

    case (state_q)
      S_IDLE: begin
        if (data_valid_i) begin
          state_d = S_SHIFT;
          half_d  = '0;
          low_d   = 1'b0;
          bit_d   = 5'd0;
          for (int i = 0; i < NUM_DEVICES; i++) begin
            shift_d[i] = {2'b00, pd_i, data_i[12*i +: 12]};
          end
        end
      end
      S_SHIFT: begin
        if (!half_end) begin
          half_d = half_q + HW'(1);
        end else begin
          half_d = '0;
          if (!low_q) begin
            low_d = 1'b1;
          end else begin
            // End of a bit: the falling edge already happened mid-bit, so the
            // next bit can be presented now with a full half-period of setup.
            low_d = 1'b0;
            bit_d = bit_q + 5'd1;
            for (int i = 0; i < NUM_DEVICES; i++) begin
              shift_d[i] = {shift_q[i][14:0], 1'b0};
            end
            if (bit_q == 5'd15) begin
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        // The gap reuses the half/low counters: one full SCLK period of SYNC_n high.
        if (!half_end) begin
          half_d = half_q + HW'(1);
        end else begin
          half_d = '0;
          if (!low_q) begin
            low_d = 1'b1;
          end else begin
            low_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        half_d  = '0;
        low_d   = 1'b0;
      end
    endcase

    // Outputs are computed from next state and registered, so every pin is a
    // flop output with no path from the inputs.
    ready_d  = (state_d == S_IDLE);
    done_d   = (state_q == S_SHIFT) && (state_d == S_GAP);
    sclk_d   = !((state_d == S_SHIFT) && low_d);
    sync_n_d = (state_d != S_SHIFT);
    for (int i = 0; i < NUM_DEVICES; i++) begin
      sdata_d[i] = (state_d == S_SHIFT) ? shift_d[i][15] : 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q  <= S_IDLE;
      half_q   <= '0;
      low_q    <= 1'b0;
      bit_q    <= 5'd0;
      for (int i = 0; i < NUM_DEVICES; i++) begin
        shift_q[i] <= 16'h0000;
      end
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      sdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      low_q    <= low_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      sdata_q  <= sdata_d;
    end
  end

  assign ready_o      = ready_q;
  assign frame_done_o = done_q;
  assign sclk_o       = sclk_q;
  assign sync_n_o     = sync_n_q;
  assign sdata_o      = sdata_q;

endmodule

// File: tb/tb_dac121s101_interface.sv
// -----------------------------------------------------------------------------
// tb_dac121s101_interface
//   Directed bench for dac121s101_interface. Instance 0 runs with H=2
//   (100 MHz / 25 MHz), instance 1 with H=1 (50 MHz / 25 MHz), both on the same
//   clk. A per-device monitor decodes SYNC_n/SCLK/SDATA into 16-bit words on
//   SCLK falling edges and checks each finished frame against exp_q0/exp_q1.
// -----------------------------------------------------------------------------
module tb_dac121s101_interface;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic [23:0] data_w  [2];
  logic [1:0]  pd_w    [2];
  logic [1:0]  valid_w;
  logic [1:0]  ready_w;
  logic [1:0]  done_w;
  logic [1:0]  sclk_w;
  logic [1:0]  sync_w;
  logic [1:0]  sdata_w [2];

  dac121s101_interface #(
    .CLK_FREQ_HZ (100_000_000),
    .SCLK_FREQ_HZ(25_000_000),
    .NUM_DEVICES (2)
  ) dut0 (
    .clk_i       (clk),
    .rst         (rst),
    .data_i      (data_w[0]),
    .pd_i        (pd_w[0]),
    .data_valid_i(valid_w[0]),
    .ready_o     (ready_w[0]),
    .frame_done_o(done_w[0]),
    .sclk_o      (sclk_w[0]),
    .sync_n_o    (sync_w[0]),
    .sdata_o     (sdata_w[0])
  );

  dac121s101_interface #(
    .CLK_FREQ_HZ (50_000_000),
    .SCLK_FREQ_HZ(25_000_000),
    .NUM_DEVICES (2)
  ) dut1 (
    .clk_i       (clk),
    .rst         (rst),
    .data_i      (data_w[1]),
    .pd_i        (pd_w[1]),
    .data_valid_i(valid_w[1]),
    .ready_o     (ready_w[1]),
    .frame_done_o(done_w[1]),
    .sclk_o      (sclk_w[1]),
    .sync_n_o    (sync_w[1]),
    .sdata_o     (sdata_w[1])
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q0[$];   // {device1 word, device0 word}
  logic [31:0] exp_q1[$];

  int          edges  [2];
  int          stray  [2];
  logic        abort_x[2];  // next frame end is an expected reset abort
  logic [15:0] cap_lo [2];
  logic [15:0] cap_hi [2];
  logic        prev_sclk[2];
  logic        prev_sync[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      edges[d] = 0; stray[d] = 0; abort_x[d] = 1'b0;
      cap_lo[d] = '0; cap_hi[d] = '0;
      prev_sclk[d] = 1'b1; prev_sync[d] = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sync_w[d] === 1'b0 && prev_sync[d] === 1'b1) begin
        edges[d] = 0;
      end
      if (prev_sclk[d] === 1'b1 && sclk_w[d] === 1'b0) begin
        if (sync_w[d] === 1'b0) begin
          edges[d]++;
          cap_lo[d] = {cap_lo[d][14:0], sdata_w[d][0]};
          cap_hi[d] = {cap_hi[d][14:0], sdata_w[d][1]};
        end else begin
          stray[d]++;
        end
      end
      if (sync_w[d] === 1'b1 && prev_sync[d] === 1'b0) begin
        if (abort_x[d]) begin
          check("abort_edges", 32'(edges[d]), 32'd7);
          abort_x[d] = 1'b0;
        end else begin
          check("frame_edges", 32'(edges[d]), 32'd16);
          if (d == 0) begin
            if (exp_q0.size() == 0) check("unexpected_frame0", 32'd1, 32'd0);
            else check("frame0", {cap_hi[d], cap_lo[d]}, exp_q0.pop_front());
          end else begin
            if (exp_q1.size() == 0) check("unexpected_frame1", 32'd1, 32'd0);
            else check("frame1", {cap_hi[d], cap_lo[d]}, exp_q1.pop_front());
          end
        end
      end
      prev_sclk[d] = sclk_w[d];
      prev_sync[d] = sync_w[d];
    end
  end

  // ---------------- driver tasks ----------------
  // Called with ready_w[d] high; the current cycle is the accept cycle t0.
  // Offsets are counted relative to t0.
  task automatic send(input int d, input logic [23:0] data, input logic [1:0] pd,
                      input logic [31:0] exp, output int fall_off, output int sync_off,
                      output int done_off, output int ready_off, output int done_cnt);
    int off;
    data_w[d]  = data;
    pd_w[d]    = pd;
    valid_w[d] = 1'b1;
    if (d == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
    check("accept_ready", 32'(ready_w[d]), 32'd1);
    tick();
    valid_w[d] = 1'b0;
    check("t1_sync", 32'(sync_w[d]), 32'd0);
    check("t1_sclk", 32'(sclk_w[d]), 32'd1);
    check("t1_ready", 32'(ready_w[d]), 32'd0);
    check("t1_msb", 32'(sdata_w[d]), 32'd0);
    fall_off = -1; sync_off = -1; done_off = -1; ready_off = -1; done_cnt = 0;
    off = 1;
    while (off < 200) begin
      tick();
      off++;
      if (!sclk_w[d] && fall_off < 0) fall_off = off;
      if (sync_w[d] && sync_off < 0) sync_off = off;
      if (done_w[d]) begin
        done_cnt++;
        if (done_off < 0) done_off = off;
      end
      if (ready_w[d]) begin
        ready_off = off;
        break;
      end
    end
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (!ready_w[d] && n < 200) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(ready_w[d]), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fo, so, dof, ro, dc, off, gap, quiet;
    valid_w = 2'b00;
    for (int d = 0; d < 2; d++) begin
      data_w[d] = '0;
      pd_w[d]   = '0;
    end

    // Reset: outputs at idle values during and after a 3-cycle reset.
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(ready_w[d]), 32'd1);
      check("rst_done", 32'(done_w[d]), 32'd0);
      check("rst_sync", 32'(sync_w[d]), 32'd1);
      check("rst_sclk", 32'(sclk_w[d]), 32'd1);
      check("rst_sdata", 32'(sdata_w[d]), 32'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(ready_w[0]), 32'd1);
    check("post_rst_sync", 32'(sync_w[0]), 32'd1);
    check("post_rst_sclk", 32'(sclk_w[0]), 32'd1);

    // Single frame, H=2.
    send(0, {12'hA5C, 12'h3F1}, 2'b00, 32'h0A5C_03F1, fo, so, dof, ro, dc);
    check("h2_first_fall", 32'(fo), 32'd3);
    check("h2_sync_rise", 32'(so), 32'd65);
    check("h2_done_off", 32'(dof), 32'd65);
    check("h2_done_cnt", 32'(dc), 32'd1);
    check("h2_ready_off", 32'(ro), 32'd69);

    // Power-down field and all-ones data, H=2.
    tick();
    send(0, 24'hFFF_FFF, 2'b11, 32'h3FFF_3FFF, fo, so, dof, ro, dc);
    check("pd_ready_off", 32'(ro), 32'd69);

    // Same with H=1: frame is 35 cycles.
    send(1, 24'hFFF_FFF, 2'b11, 32'h3FFF_3FFF, fo, so, dof, ro, dc);
    check("h1_first_fall", 32'(fo), 32'd2);
    check("h1_sync_rise", 32'(so), 32'd33);
    check("h1_done_off", 32'(dof), 32'd33);
    check("h1_done_cnt", 32'(dc), 32'd1);
    check("h1_ready_off", 32'(ro), 32'd35);

    // Back-to-back with data_valid_i held high.
    data_w[0] = {12'h123, 12'h456};
    pd_w[0]   = 2'b00;
    valid_w[0] = 1'b1;
    exp_q0.push_back(32'h0123_0456);
    tick();
    data_w[0] = {12'hFED, 12'hCBA};
    pd_w[0]   = 2'b01;
    exp_q0.push_back(32'h1FED_1CBA);
    off = 1; gap = 0;
    while (off < 200 && !ready_w[0]) begin
      tick();
      off++;
      if (sync_w[0]) gap++;
    end
    check("b2b_accept_off", 32'(off), 32'd69);
    check("b2b_sync_gap", 32'(gap), 32'd5);
    tick();
    valid_w[0] = 1'b0;
    check("b2b_second_sync", 32'(sync_w[0]), 32'd0);
    wait_ready(0);

    // Busy ignore: new data and a valid pulse mid-frame are not taken.
    tick();
    data_w[0]  = {12'h800, 12'h001};
    pd_w[0]    = 2'b00;
    valid_w[0] = 1'b1;
    exp_q0.push_back(32'h0800_0001);
    tick();
    valid_w[0] = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    data_w[0]  = {12'h555, 12'hAAA};
    pd_w[0]    = 2'b11;
    valid_w[0] = 1'b1;
    tick();
    valid_w[0] = 1'b0;
    wait_ready(0);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sync_w[0]) quiet++;
    end
    check("busy_no_extra_frame", 32'(quiet), 32'd10);

    // Mid-frame reset after the 7th falling edge.
    data_w[0]  = {12'h0F0, 12'h00F};
    pd_w[0]    = 2'b00;
    valid_w[0] = 1'b1;
    abort_x[0] = 1'b1;
    tick();
    valid_w[0] = 1'b0;
    off = 0;
    while (edges[0] < 7 && off < 200) begin
      tick();
      off++;
    end
    check("abort_reach7", 32'(edges[0]), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_sync", 32'(sync_w[0]), 32'd1);
    check("abort_sclk", 32'(sclk_w[0]), 32'd1);
    check("abort_sdata", 32'(sdata_w[0]), 32'd0);
    check("abort_ready", 32'(ready_w[0]), 32'd1);
    check("abort_done", 32'(done_w[0]), 32'd0);
    tick();
    check("abort_done_next", 32'(done_w[0]), 32'd0);

    // Next frame after the abort is intact.
    send(0, {12'h7E7, 12'h181}, 2'b10, 32'h27E7_2181, fo, so, dof, ro, dc);
    check("after_abort_ready_off", 32'(ro), 32'd69);
    tick();

    check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    check("stray_sclk0", 32'(stray[0]), 32'd0);
    check("stray_sclk1", 32'(stray[1]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
